// File: rtl/corr_engine.sv
`default_nettype none
// ============================================================================
//  Module   : corr_engine
//  Purpose  : Template-match correlator. Streams one TPL_W x TPL_H window out
//             of frame and template RAMs and reports the unsigned sum of
//             pixel products.
//  Revision : 1.0  initial release
// ============================================================================
module corr_engine #(
    parameter int TPL_W = 16,
    parameter int TPL_H = 16,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int PIX_W = 8
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iFrameDone,
    input  logic             iScanDone,
    input  logic [12:0]      iX,
    input  logic [12:0]      iY,
    output logic [18:0]      oFrameAddr,
    input  logic [PIX_W-1:0] iFramePix,
    output logic [15:0]      oTplAddr,
    input  logic [PIX_W-1:0] iTplPix,
    output logic [31:0]      oCurrentCorr,
    output logic             oCorrFinished,
    output logic             oBusy
);

    localparam int TXW = (TPL_W > 1) ? $clog2(TPL_W) : 1;
    localparam int TYW = (TPL_H > 1) ? $clog2(TPL_H) : 1;
    localparam int PW2 = 2 * PIX_W;

    localparam logic [TXW-1:0] c_TX_LAST    = TXW'(TPL_W - 1);
    localparam logic [TYW-1:0] c_TY_LAST    = TYW'(TPL_H - 1);
    localparam logic [13:0]    c_IMG_W      = 14'(IMG_W);
    localparam logic [13:0]    c_IMG_H      = 14'(IMG_H);
    localparam logic [31:0]    c_ROW_STRIDE = 32'(IMG_W);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_RUN    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t r_state;
    state_t w_nextState;
    logic   r_phase;

    // Indices and geometry of the pixel whose address is currently presented
    logic [TXW-1:0] r_tx;
    logic [TYW-1:0] r_ty;
    logic [13:0]    r_x0;
    logic [13:0]    r_col;
    logic [13:0]    r_row;
    logic [31:0]    r_rowBase;
    logic           r_inb;

    logic [TXW-1:0] w_tx;
    logic [TYW-1:0] w_ty;
    logic [13:0]    w_col;
    logic [13:0]    w_row;
    logic [31:0]    w_rowBase;
    logic           w_inb;
    logic [18:0]    w_frameAddr;

    logic           w_latch;
    logic           w_lastPix;
    logic           w_issue;

    logic           r_inbD;
    logic [PW2-1:0] w_prod;
    logic [PW2-1:0] r_prod;
    logic [31:0]    r_acc;

    assign w_latch   = (r_state == ST_SETTLE) && r_phase;
    assign w_lastPix = (r_tx == c_TX_LAST) && (r_ty == c_TY_LAST);
    assign w_issue   = w_latch || ((r_state == ST_RUN) && !w_lastPix);
    assign w_prod    = PW2'(iFramePix) * PW2'(iTplPix);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state <= ST_IDLE;
            r_phase <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_phase <= (w_nextState == r_state) ? ~r_phase : 1'b0;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE:   if (iFrameDone && !iScanDone) w_nextState = ST_SETTLE;
            ST_SETTLE: if (r_phase)                  w_nextState = ST_RUN;
            ST_RUN:    if (w_lastPix)                w_nextState = ST_DRAIN;
            ST_DRAIN:  if (r_phase)                  w_nextState = ST_DONE;
            ST_DONE:                                 w_nextState = ST_IDLE;
            default:                                 w_nextState = ST_IDLE;
        endcase
    end

    assign oCorrFinished = (r_state == ST_DONE);
    assign oBusy         = (r_state != ST_IDLE);

    // ------------------------------------------------------------------
    // Next raster position; the latch cycle seeds it from the live origin
    // ------------------------------------------------------------------
    always_comb begin
        w_tx      = r_tx + 1'b1;
        w_ty      = r_ty;
        w_col     = r_col + 14'd1;
        w_row     = r_row;
        w_rowBase = r_rowBase;
        if (w_latch) begin
            w_tx      = '0;
            w_ty      = '0;
            w_col     = {1'b0, iX};
            w_row     = {1'b0, iY};
            w_rowBase = 32'(iY) * c_ROW_STRIDE;
        end else if (r_tx == c_TX_LAST) begin
            w_tx      = '0;
            w_ty      = r_ty + 1'b1;
            w_col     = r_x0;
            w_row     = r_row + 14'd1;
            w_rowBase = r_rowBase + c_ROW_STRIDE;
        end
        w_inb       = (w_col < c_IMG_W) && (w_row < c_IMG_H);
        w_frameAddr = 19'(w_rowBase + 32'(w_col));
    end

    // ------------------------------------------------------------------
    // Address generation, product pipeline and accumulator
    // ------------------------------------------------------------------
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_tx         <= '0;
            r_ty         <= '0;
            r_x0         <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_rowBase    <= '0;
            r_inb        <= 1'b0;
            r_inbD       <= 1'b0;
            r_prod       <= '0;
            r_acc        <= '0;
            oFrameAddr   <= '0;
            oTplAddr     <= '0;
            oCurrentCorr <= '0;
        end else begin
            // Out-of-bounds pixels flow through as zero products
            r_inbD <= (r_state == ST_RUN) && r_inb;
            r_prod <= r_inbD ? w_prod : '0;

            if (w_latch) begin
                r_x0 <= {1'b0, iX};
            end

            if (w_issue) begin
                r_tx      <= w_tx;
                r_ty      <= w_ty;
                r_col     <= w_col;
                r_row     <= w_row;
                r_rowBase <= w_rowBase;
                r_inb     <= w_inb;
                oTplAddr  <= w_latch ? 16'd0 : oTplAddr + 16'd1;
                if (w_inb) begin
                    oFrameAddr <= w_frameAddr;
                end
            end else if (r_state == ST_RUN) begin
                r_inb <= 1'b0;
            end

            if (r_state == ST_DONE) begin
                oFrameAddr <= '0;
                oTplAddr   <= '0;
            end

            if (w_latch) begin
                r_acc <= '0;
            end else if ((r_state == ST_RUN) || (r_state == ST_DRAIN)) begin
                r_acc <= r_acc + 32'(r_prod);
            end

            // The final product is still in flight on the last DRAIN cycle
            if ((r_state == ST_DRAIN) && r_phase) begin
                oCurrentCorr <= r_acc + 32'(r_prod);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_corr_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_corr_engine
//  Purpose  : Randomized self-checking bench for corr_engine against a
//             window-level correlation model with behavioural RAMs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_corr_engine;

    localparam int TW = 16;
    localparam int TH = 16;
    localparam int IW = 640;
    localparam int IH = 480;
    localparam int N  = TW * TH;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iFrameDone;
    logic        iScanDone;
    logic [12:0] iX;
    logic [12:0] iY;
    logic [18:0] oFrameAddr;
    logic [7:0]  iFramePix;
    logic [15:0] oTplAddr;
    logic [7:0]  iTplPix;
    logic [31:0] oCurrentCorr;
    logic        oCorrFinished;
    logic        oBusy;

    corr_engine #(
        .TPL_W(TW), .TPL_H(TH), .IMG_W(IW), .IMG_H(IH), .PIX_W(8)
    ) dut (
        .iCLK(iCLK), .iRST(iRST), .iFrameDone(iFrameDone), .iScanDone(iScanDone),
        .iX(iX), .iY(iY), .oFrameAddr(oFrameAddr), .iFramePix(iFramePix),
        .oTplAddr(oTplAddr), .iTplPix(iTplPix), .oCurrentCorr(oCurrentCorr),
        .oCorrFinished(oCorrFinished), .oBusy(oBusy)
    );

    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    int         frameMode = 0;
    int         tplMode   = 0;
    logic [7:0] tplMem [N];

    // Expected window: busy winStart..winEnd, pulse at winEnd
    int     winStart = -10;
    int     winEnd   = -10;
    int     wx = 0;
    int     wy = 0;
    longint winCorr  = 0;
    longint prevCorr = 0;
    bit     chk = 1'b0;

    function automatic logic [7:0] fval(input int addr);
        logic [31:0] h;
        case (frameMode)
            0: return 8'd1;
            1: return 8'hFF;
            2: return 8'(addr % 251);
            default: begin
                h = 32'(addr) * 32'h9E3779B1;
                return h[31:24];
            end
        endcase
    endfunction

    function automatic logic [7:0] tval(input int idx);
        case (tplMode)
            0: return 8'd1;
            1: return 8'hFF;
            default: return (idx < N) ? tplMem[idx] : 8'd0;
        endcase
    endfunction

    function automatic longint corrModel(input int x, input int y);
        longint s = 0;
        for (int ty = 0; ty < TH; ty++)
            for (int tx = 0; tx < TW; tx++)
                if (x + tx < IW && y + ty < IH)
                    s += longint'(fval((y + ty) * IW + x + tx)) * longint'(tval(ty * TW + tx));
        return s;
    endfunction

    // Synchronous-read RAMs
    always @(posedge iCLK) begin
        iFramePix <= fval(int'(oFrameAddr));
        iTplPix   <= tval(int'(oTplAddr));
    end

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge iCLK);
        #1;
    endtask

    // Per-cycle comparison against the window model
    logic   eBusy;
    int     ci, ccol, crow;
    longint lastAddr = 0;
    always @(negedge iCLK) begin
        if (chk) begin
            eBusy = (cyc >= winStart) && (cyc <= winEnd);
            check("busy", longint'(oBusy), longint'(eBusy));
            check("finished", longint'(oCorrFinished), longint'(cyc == winEnd));
            check("corr", longint'(oCurrentCorr), (cyc >= winEnd) ? winCorr : prevCorr);
            if (!eBusy) begin
                check("frameAddrIdle", longint'(oFrameAddr), 0);
                check("tplAddrIdle", longint'(oTplAddr), 0);
            end else begin
                ci = cyc - winStart - 2;
                if (ci == 0) lastAddr = 0;
                if (ci >= 0 && ci < N) begin
                    ccol = wx + ci % TW;
                    crow = wy + ci / TW;
                    if (ccol < IW && crow < IH) lastAddr = longint'(crow) * IW + ccol;
                    check("tplAddr", longint'(oTplAddr), ci);
                    check("frameAddr", longint'(oFrameAddr), lastAddr);
                end
            end
        end
    end

    // Runs one window starting in the current cycle; abortAt>=0 resets at that RUN cycle
    task automatic startWindow(input int x, input int y, input int abortAt);
        while (cyc < winEnd + 1) nextCycle();
        iX = 13'(x); iY = 13'(y); iFrameDone = 1'b1; iScanDone = 1'b0;
        prevCorr = winCorr;
        wx = x; wy = y;
        winCorr  = corrModel(x, y);
        winStart = cyc + 1;
        winEnd   = cyc + N + 5;
        while (cyc < winEnd) begin
            nextCycle();
            if (abortAt >= 0 && cyc == winStart + 2 + abortAt) begin
                iRST = 1'b1; iFrameDone = 1'b0; iScanDone = 1'b0;
                nextCycle();
                iRST = 1'b0;
                winStart = -10; winEnd = -10; winCorr = 0; prevCorr = 0;
                @(negedge iCLK);
                check("abortBusy", longint'(oBusy), 0);
                check("abortPulse", longint'(oCorrFinished), 0);
                check("abortCorr", longint'(oCurrentCorr), 0);
                return;
            end
            iFrameDone = 1'($urandom);
            iScanDone  = 1'($urandom);
            if (cyc >= winStart + 2) begin
                iX = 13'($urandom);
                iY = 13'($urandom);
            end
        end
        nextCycle();
        iFrameDone = 1'b0; iScanDone = 1'b0;
    endtask

    initial begin
        iRST = 1'b1; iFrameDone = 1'b0; iScanDone = 1'b0; iX = '0; iY = '0;
        for (int i = 0; i < N; i++) tplMem[i] = 8'($urandom);
        repeat (2) @(posedge iCLK);
        @(negedge iCLK);
        check("rstBusy", longint'(oBusy), 0);
        check("rstPulse", longint'(oCorrFinished), 0);
        check("rstCorr", longint'(oCurrentCorr), 0);
        check("rstFrameAddr", longint'(oFrameAddr), 0);
        check("rstTplAddr", longint'(oTplAddr), 0);
        nextCycle();
        iRST = 1'b0;
        chk  = 1'b1;

        // Hand-computed anchors
        frameMode = 0; tplMode = 0;
        startWindow(0, 0, -1);
        check("ones00", longint'(oCurrentCorr), 256);
        startWindow(630, 0, -1);
        check("onesEdge", longint'(oCurrentCorr), 160);
        frameMode = 1; tplMode = 1;
        startWindow(100, 100, -1);
        check("max255", longint'(oCurrentCorr), 64'h00FE0100);

        // Reset mid-window, then a clean restart
        frameMode = 0; tplMode = 0;
        startWindow(5, 7, 100);
        startWindow(0, 0, -1);
        check("restart", longint'(oCurrentCorr), 256);

        // Start conditions never met
        for (int i = 0; i < 1000; i++) begin
            iFrameDone = 1'($urandom);
            iScanDone  = iFrameDone ? 1'b1 : 1'($urandom);
            iX = 13'($urandom); iY = 13'($urandom);
            nextCycle();
        end
        iFrameDone = 1'b0; iScanDone = 1'b0;

        // Back-to-back windows on a ramp frame
        frameMode = 2; tplMode = 2;
        startWindow(0, 0, -1);
        startWindow(1, 0, -1);

        // Randomized windows, biased toward the frame edges
        for (int k = 0; k < 14; k++) begin
            frameMode = int'($urandom_range(0, 3));
            tplMode   = int'($urandom_range(0, 2));
            for (int i = 0; i < N; i++) tplMem[i] = 8'($urandom);
            if (k % 2 == 0)
                startWindow(int'($urandom_range(IW - TW, IW + 4)), int'($urandom_range(IH - TH, IH + 4)), -1);
            else
                startWindow(int'($urandom_range(0, IW - 1)), int'($urandom_range(0, IH - 1)), -1);
        end

        repeat (3) nextCycle();
        chk = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
